pipe_stage_latch: RTL

// - Generic pipeline latch between two datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB), one parametrised block for all four.
// - Carries a data bundle and a control bundle with a valid/ready handshake.
// - Supports synchronous flush with bubble insertion: control forced to NOP.
// - Provides a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_latch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_latch.sv
// Generic valid/ready pipeline latch with flush-to-bubble and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a registered-ready skid entry (capacity 2).
module pipe_stage_latch #(
  parameter int unsigned              DATA_W   = 32,
  parameter int unsigned              CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]        NOP_CTRL = '0,
  parameter int unsigned              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;

  assign accept = in_valid & in_ready;
  assign emit   = main_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Ready comes straight from a flop, so out_ready never reaches in_ready.
  assign in_ready = ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_ctrl_d  = NOP_CTRL;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_ctrl_d  = NOP_CTRL;
    end else if (emit) begin
      if (skid_valid_q) begin
        // No accept is possible here: in_ready is low while the skid is full.
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = NOP_CTRL;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= NOP_CTRL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`else
  assign in_ready = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_ctrl_d  = NOP_CTRL;
    end else if (accept) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
      main_ctrl_d  = in_ctrl;
    end else if (emit) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = NOP_CTRL;
    end
  end
`endif

  always_comb begin
    stall_d = stall_q;
    if (main_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= NOP_CTRL;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      stall_q      <= stall_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign stall_cnt = stall_q;

endmodule
